// File: rtl/systolic_array_ctrl_if.sv
// Operand stream, job handshake and array drive bundle between the matrix-unit
// sequencer (master) and the operand buffer / array side (slave).
interface systolic_array_ctrl_if #(
    parameter int DATA_BITS  = 16,
    parameter int ARRAY_SIZE = 4,
    parameter int K_BITS     = 8
);
    localparam int W = ARRAY_SIZE * DATA_BITS;

    logic              start;
    logic [K_BITS-1:0] k_len;
    logic              busy;
    logic              done;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_data;
    logic              arr_enable;
    logic              arr_clear_acc;
    logic              arr_load_weights;
    logic              arr_compute_enable;
    logic [W-1:0]      arr_a_inputs;
    logic [W-1:0]      arr_b_inputs;

    modport master (
        input  start, k_len, in_valid, in_data,
        output busy, done, in_ready,
        output arr_enable, arr_clear_acc, arr_load_weights, arr_compute_enable,
        output arr_a_inputs, arr_b_inputs
    );

    modport slave (
        output start, k_len, in_valid, in_data,
        input  busy, done, in_ready,
        input  arr_enable, arr_clear_acc, arr_load_weights, arr_compute_enable,
        input  arr_a_inputs, arr_b_inputs
    );
endinterface

// File: rtl/systolic_array_ctrl.sv
// Systolic array sequencer: clear, N weight beats, K skewed activation beats, flush, done pulse.
// Define SYSTOLIC_ARRAY_CTRL_PERF_EN to add the perf_stall_cycles counter output.
module systolic_array_ctrl #(
    parameter int DATA_BITS  = 16,
    parameter int ARRAY_SIZE = 4,
    parameter int K_BITS     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    systolic_array_ctrl_if.master bus
`ifdef SYSTOLIC_ARRAY_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_stall_cycles
`endif
);
    localparam int W        = ARRAY_SIZE * DATA_BITS;
    localparam int CNT_BITS = K_BITS + $clog2(2 * ARRAY_SIZE);
    localparam logic [CNT_BITS-1:0] W_BEATS   = CNT_BITS'(ARRAY_SIZE);
    localparam logic [CNT_BITS-1:0] FLUSH_LEN = CNT_BITS'(2 * (ARRAY_SIZE - 1));

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_WLOAD, S_FEED, S_FLUSH, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [K_BITS-1:0]     k_q, k_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d, cnt_inc;

    logic                  rdy, beat, skew_shift, skew_clr;
    logic                  busy_w, done_w, en_w, clr_w, ld_w, ce_w;
    logic [W-1:0]          a_w, b_w;

    logic [ARRAY_SIZE-1:0][DATA_BITS-1:0] lanes_in;
    logic [ARRAY_SIZE-1:0][DATA_BITS-1:0] skew_out;

    assign lanes_in = bus.in_data;
    assign rdy      = (state_q == S_WLOAD) || (state_q == S_FEED);
    assign beat     = rdy && bus.in_valid;
    assign cnt_inc  = cnt_q + CNT_BITS'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

    // Lane 0 enters the array unskewed; lane r is delayed r enabled cycles.
    assign skew_out[0] = (beat && state_q == S_FEED) ? lanes_in[0] : '0;

    for (genvar r = 1; r < ARRAY_SIZE; r++) begin : g_skew
        logic [DATA_BITS-1:0] sr_q [r];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int s = 0; s < r; s++) sr_q[s] <= '0;
            end else if (skew_clr) begin
                for (int s = 0; s < r; s++) sr_q[s] <= '0;
            end else if (skew_shift) begin
                sr_q[0] <= (state_q == S_FEED) ? lanes_in[r] : '0;
                for (int s = 1; s < r; s++) sr_q[s] <= sr_q[s-1];
            end
        end

        assign skew_out[r] = sr_q[r-1];
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        busy_w     = (state_q != S_IDLE);
        done_w     = 1'b0;
        en_w       = 1'b0;
        clr_w      = 1'b0;
        ld_w       = 1'b0;
        ce_w       = 1'b0;
        a_w        = '0;
        b_w        = '0;
        skew_shift = 1'b0;
        skew_clr   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    k_d     = bus.k_len;
                    cnt_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                en_w     = 1'b1;
                clr_w    = 1'b1;
                skew_clr = 1'b1;
                cnt_d    = '0;
                state_d  = S_WLOAD;
            end
            S_WLOAD: begin
                en_w = bus.in_valid;
                if (beat) begin
                    b_w = bus.in_data;
                    if (cnt_inc == W_BEATS) begin
                        // The last weight beat lands each row in place, so latch now.
                        ld_w    = 1'b1;
                        cnt_d   = '0;
                        state_d = (k_q != '0) ? S_FEED : S_DONE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_FEED: begin
                en_w       = bus.in_valid;
                ce_w       = 1'b1;
                skew_shift = bus.in_valid;
                a_w        = skew_out;
                if (beat) begin
                    if (cnt_inc == CNT_BITS'(k_q)) begin
                        cnt_d   = '0;
                        state_d = S_FLUSH;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_FLUSH: begin
                en_w       = 1'b1;
                ce_w       = 1'b1;
                skew_shift = 1'b1;
                a_w        = skew_out;
                if (cnt_inc == FLUSH_LEN) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DONE: begin
                done_w  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy               = busy_w;
    assign bus.done               = done_w;
    assign bus.in_ready           = rdy;
    assign bus.arr_enable         = en_w;
    assign bus.arr_clear_acc      = clr_w;
    assign bus.arr_load_weights   = ld_w;
    assign bus.arr_compute_enable = ce_w;
    assign bus.arr_a_inputs       = a_w;
    assign bus.arr_b_inputs       = b_w;

`ifdef SYSTOLIC_ARRAY_CTRL_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_q <= '0;
        end else if (state_q == S_IDLE && bus.start) begin
            perf_q <= '0;
        end else if (rdy && !bus.in_valid && perf_q != 32'hFFFF_FFFF) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_q;
`endif
endmodule
